aes_round_ctrl: RTL and testbench

//  Sequencer for the iterative AES-128 encrypt loop: one combinational round unit feeding one pipeReg.

---
 rtl/aes_round_ctrl_pkg.sv | 15 +
 rtl/aes_round_ctrl_if.sv | 22 ++
 rtl/aes_round_ctrl.sv | 126 ++++++++++++
 tb/tb_aes_round_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_round_ctrl_pkg.sv
// Shared constants and FSM encoding for the iterative AES-128 round-loop controller.
package aes_round_ctrl_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_NUM_W = 4;
  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    OUT  = 2'd3
  } aes_ctrl_st_t;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block-in / ciphertext-out valid/ready streams of the AES round-loop controller.
interface aes_round_ctrl_if;

  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output in_valid, in_state, in_key, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, in_key, out_ready,
    output in_ready, out_valid, out_state
  );

endinterface

// File: rtl/aes_round_ctrl.sv
// Sequencer for one combinational AES round unit looped through one pipeline register:
// feeds rounds 0..NR and buffers the ciphertext on a valid/ready output.
module aes_round_ctrl
  import aes_round_ctrl_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int NUM_W = AES_NUM_W
) (
  input  logic             clk,
  input  logic             rst,
  aes_round_ctrl_if.slave  bus,
  output logic [127:0]     rnd_state_o,
  output logic [127:0]     rnd_key_o,
  output logic [NUM_W-1:0] rnd_num_o,
  output logic             pipe_en,
  input  logic             pipe_done_i,
  input  logic [127:0]     pipe_state_i,
  input  logic [127:0]     pipe_key_i,
  input  logic [NUM_W-1:0] pipe_num_i,
  output logic             busy,
  output logic             err
);

  localparam logic [NUM_W-1:0] NR_L = NUM_W'(NR);

  aes_ctrl_st_t state_r;
  logic [127:0] cap_state_r;
  logic [127:0] cap_key_r;
  logic [127:0] out_state_r;
  logic         out_valid_r;
  logic         err_r;
  logic         last_s;

  // Final round result is sitting in the pipeline register.
  assign last_s = pipe_done_i && (pipe_num_i == NR_L);

  // Round-unit operand select: captured block for round 0, loop-back afterwards.
  always_comb begin
    rnd_state_o = 128'd0;
    rnd_key_o   = 128'd0;
    rnd_num_o   = '0;
    case (state_r)
      LOAD: begin
        rnd_state_o = cap_state_r;
        rnd_key_o   = cap_key_r;
        rnd_num_o   = '0;
      end
      RUN: begin
        rnd_state_o = pipe_state_i;
        rnd_key_o   = pipe_key_i;
        rnd_num_o   = pipe_num_i + NUM_W'(1);
      end
      default: begin
        rnd_state_o = 128'd0;
        rnd_key_o   = 128'd0;
        rnd_num_o   = '0;
      end
    endcase
  end

  // Pipeline enable: dropping it clears the register, which also discards a broken block.
  always_comb begin
    pipe_en = 1'b0;
    if (rst) begin
      pipe_en = 1'b0;
    end else if (state_r == LOAD) begin
      pipe_en = 1'b1;
    end else if (state_r == RUN) begin
      pipe_en = pipe_done_i && !last_s;
    end else begin
      pipe_en = 1'b0;
    end
  end

  // Control FSM with capture, ciphertext buffer and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cap_state_r <= 128'd0;
      cap_key_r   <= 128'd0;
      out_state_r <= 128'd0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            cap_state_r <= bus.in_state;
            cap_key_r   <= bus.in_key;
            err_r       <= 1'b0;
            state_r     <= LOAD;
          end
        end
        LOAD: begin
          state_r <= RUN;
        end
        RUN: begin
          if (!pipe_done_i) begin
            err_r   <= 1'b1;
            state_r <= IDLE;
          end else if (last_s) begin
            out_state_r <= pipe_state_i;
            out_valid_r <= 1'b1;
            state_r     <= OUT;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.out_state = out_state_r;
  assign busy          = (state_r != IDLE);
  assign err           = err_r;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: behavioural round unit + pipeline register around the DUT,
// scoreboard of whole-cipher AES-128 results checked by an independent output monitor.
module tb_aes_round_ctrl;
  import aes_round_ctrl_pkg::*;

  localparam int LAT = AES_NR + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_round_ctrl_if bus ();

  logic [127:0] rnd_state_o, rnd_key_o;
  logic [3:0]   rnd_num_o;
  logic         pipe_en, busy, err;
  logic         pipe_done_i;
  logic [127:0] pq_state = 128'd0;
  logic [127:0] pq_key   = 128'd0;
  logic [3:0]   pq_num   = 4'd0;
  logic         pq_done  = 1'b0;
  logic         kill     = 1'b0;

  aes_round_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rnd_state_o(rnd_state_o), .rnd_key_o(rnd_key_o), .rnd_num_o(rnd_num_o),
    .pipe_en(pipe_en), .pipe_done_i(pipe_done_i), .pipe_state_i(pq_state),
    .pipe_key_i(pq_key), .pipe_num_i(pq_num), .busy(busy), .err(err)
  );

  // ---------------- AES-128 helpers (FIPS-197 byte order, byte 0 = MSB) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    logic [7:0] base = a;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, base);
      base = gmul(base, base);
    end
    if (a == 8'h00) r = 8'h00;
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input int n);
    logic [7:0] r = 8'h01;
    for (int i = 1; i < n; i++) r = xt(r);
    return r;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input int n);
    logic [31:0] t, n0, n1, n2, n3;
    t  = subword({k[23:0], k[31:24]}) ^ {rcon(n), 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk, input bit mix);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      if (mix) begin
        b[4*c]   = xt(t[4*c])   ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
        b[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
        b[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
        b[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
      end else begin
        for (int r = 0; r < 4; r++) b[4*c+r] = t[4*c+r];
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ rk;
  endfunction

  // Whole-cipher reference used by the scoreboard.
  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s = pt ^ key;
    logic [127:0] k = key;
    for (int r = 1; r <= AES_NR; r++) begin
      k = expand(k, r);
      s = enc_round(s, k, r != AES_NR);
    end
    return s;
  endfunction

  // Round unit + pipeline register seen by the controller (en low clears it).
  always @(posedge clk) begin
    if (pipe_en) begin
      pq_key   <= (rnd_num_o == 4'd0) ? rnd_key_o : expand(rnd_key_o, int'(rnd_num_o));
      pq_state <= (rnd_num_o == 4'd0) ? (rnd_state_o ^ rnd_key_o)
                : enc_round(rnd_state_o, expand(rnd_key_o, int'(rnd_num_o)), int'(rnd_num_o) != AES_NR);
      pq_num   <= rnd_num_o;
      pq_done  <= 1'b1;
    end else begin
      pq_key   <= 128'd0;
      pq_state <= 128'd0;
      pq_num   <= 4'd0;
      pq_done  <= 1'b0;
    end
  end
  assign pipe_done_i = pq_done & ~kill;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [127:0] ct;
    int           acc;
  } exp_t;

  exp_t         exp_q [$];
  logic [3:0]   rn_seq [$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  bit           blk_expect = 1'b0;
  logic [127:0] last_out = 128'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Output monitor: push on accept, pop and compare on every ciphertext handshake.
  initial begin : monitor
    exp_t e;
    bit   prev_ov = 1'b0;
    int   ov_rise = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.in_valid && bus.in_ready && blk_expect)
          exp_q.push_back('{ct: aes_encrypt(bus.in_state, bus.in_key), acc: cyc});
        if (bus.out_valid && !prev_ov) ov_rise = cyc;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", bus.out_state, 128'd0);
          end else begin
            e = exp_q.pop_front();
            chk("out_state", bus.out_state, e.ct);
            chk("latency", 128'(ov_rise - e.acc), 128'(LAT));
            last_out = bus.out_state;
          end
        end
        if (pipe_en) rn_seq.push_back(rnd_num_o);
      end
      prev_ov = bus.out_valid;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Starts and ends just after a rising edge.
  task automatic send(input logic [127:0] s, input logic [127:0] k, input bit ex, output int acc_cyc);
    bit acc = 1'b0;
    int n = 0;
    acc_cyc = -1;
    blk_expect = ex;
    bus.in_state = s;
    bus.in_key   = k;
    bus.in_valid = 1'b1;
    while (!acc && n < 60) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) acc_cyc = cyc;
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    chk("accept_timeout", 128'(acc), 128'd1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = (exp_q.size() == 0) && !busy;
    end
    @(posedge clk); #1;
    chk("drain_timeout", 128'(ok), 128'd1);
  endtask

  task automatic wait_round(input logic [3:0] num, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = busy && pipe_done_i && (pq_num == num);
    end
  endtask

  initial begin : stim
    int  a1, a2, dummy;
    bit  seen;
    logic [127:0] held;
    bus.in_valid  = 1'b0;
    bus.in_state  = 128'd0;
    bus.in_key    = 128'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_state", bus.out_state, 128'd0);
    chk("rst_pipe_en", 128'(pipe_en), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk); #1;

    // FIPS-197 C.1 vector, also tracing the round-number sequence.
    rn_seq.delete();
    send(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 1'b1, a1);
    drain();
    chk("fips_ct", last_out, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("pipe_en_cycles", 128'(rn_seq.size()), 128'(AES_NR + 1));
    for (int i = 0; i < rn_seq.size() && i <= AES_NR; i++)
      chk("rnd_num_seq", 128'(rn_seq[i]), 128'(i));

    // Back-pressure in OUT: output held, input ignored.
    bus.out_ready = 1'b0;
    send(rnd128(), rnd128(), 1'b1, a1);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    chk("out_valid_rise", 128'(seen), 128'd1);
    held = bus.out_state;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.in_valid = i[0];
      bus.in_state = rnd128();
      @(negedge clk);
      chk("hold_out_valid", 128'(bus.out_valid), 128'd1);
      chk("hold_out_state", bus.out_state, held);
      chk("hold_in_ready", 128'(bus.in_ready), 128'd0);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Reset in the middle of round 4, then a clean block.
    send(rnd128(), rnd128(), 1'b0, dummy);
    wait_round(4'd4, seen);
    chk("reach_round4", 128'(seen), 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("midrst_pipe_en", 128'(pipe_en), 128'd0);
    @(posedge clk); #1;
    send(rnd128(), rnd128(), 1'b1, dummy);
    drain();

    // Two blocks back to back with out_ready high.
    send(rnd128(), rnd128(), 1'b1, a1);
    send(rnd128(), rnd128(), 1'b1, a2);
    chk("accept_gap", 128'(a2 - a1), 128'(AES_NR + 4));
    drain();

    // Missing pipeline done mid-block.
    send(rnd128(), rnd128(), 1'b0, dummy);
    wait_round(4'd3, seen);
    chk("reach_round3", 128'(seen), 128'd1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    chk("err_set", 128'(err), 128'd1);
    chk("err_busy", 128'(busy), 128'd0);
    chk("err_out_valid", 128'(bus.out_valid), 128'd0);
    chk("err_pipe_en", 128'(pipe_en), 128'd0);
    @(posedge clk); #1;
    send(rnd128(), rnd128(), 1'b1, dummy);
    @(negedge clk);
    chk("err_cleared", 128'(err), 128'd0);
    @(posedge clk); #1;
    drain();

    // Randomised blocks with random output stalls.
    for (int i = 0; i < 6; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      send(rnd128(), rnd128(), 1'b1, dummy);
      repeat ($urandom_range(12, 18)) @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
